// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory port of the unified
// memory arbiter. The arbiter uses the slave view; requesters and memory
// use the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  // data port
  logic                d_req;
  logic                d_we;
  logic                d_dbl;
  logic [ADDR_W-1:0]   d_addr;
  logic [2*DATA_W-1:0] d_wdata;
  logic                d_gnt;
  logic                d_valid;
  logic [2*DATA_W-1:0] d_rdata;

  // memory port
  logic              mem_r;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] mem_addr_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_dbl, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output mem_r, mem_wr, mem_addr_r, mem_addr_wr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_dbl, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  mem_r, mem_wr, mem_addr_r, mem_addr_wr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port arbiter in front of the unified instruction/data memory.
// Data requests normally win; a waiting fetch is forced through after
// STARVE_LIMIT back-to-back data grants. Double-word data accesses are
// split into two word transfers (high half at addr, low half at addr+1).
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  state_t              state_reg, state_next;
  logic                owner_d_reg;   // 1 = data port owns the transfer
  logic                we_reg;
  logic                dbl_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [2*DATA_W-1:0] wdata_reg;
  logic [CNT_W-1:0]    starve_reg;
  logic [DATA_W-1:0]   hold_reg;      // first word of a double read
  logic [DATA_W-1:0]   if_rdata_reg;
  logic [2*DATA_W-1:0] d_rdata_reg;

  logic              any_req;
  logic              starved;
  logic              fetch_win;
  logic [ADDR_W-1:0] addr_inc;

  assign any_req   = bus.if_req | bus.d_req;
  assign starved   = (starve_reg == LIMIT);
  assign fetch_win = bus.if_req & (~bus.d_req | starved);
  // second word address wraps naturally modulo 2^ADDR_W
  assign addr_inc  = addr_reg + ADDR_W'(1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACC0;
      ACC0:    state_next = dbl_reg ? ACC1 : RESP;
      ACC1:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // latch the winning request and update the starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d_reg <= 1'b0;
      we_reg      <= 1'b0;
      dbl_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      starve_reg  <= '0;
    end else if (state_reg == IDLE && any_req) begin
      if (fetch_win) begin
        owner_d_reg <= 1'b0;
        we_reg      <= 1'b0;
        dbl_reg     <= 1'b0;
        addr_reg    <= bus.if_addr;
        wdata_reg   <= '0;
        starve_reg  <= '0;
      end else begin
        owner_d_reg <= 1'b1;
        we_reg      <= bus.d_we;
        dbl_reg     <= bus.d_dbl;
        addr_reg    <= bus.d_addr;
        wdata_reg   <= bus.d_wdata;
        if (!bus.if_req)  starve_reg <= '0;
        else if (!starved) starve_reg <= starve_reg + CNT_W'(1);
      end
    end
  end

  // capture read data; port rdata registers change only on their own read completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg     <= '0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else if (!we_reg) begin
      if (state_reg == ACC0) begin
        if (!owner_d_reg)  if_rdata_reg <= bus.mem_rdata;
        else if (dbl_reg)  hold_reg     <= bus.mem_rdata;
        else               d_rdata_reg  <= {{DATA_W{1'b0}}, bus.mem_rdata};
      end else if (state_reg == ACC1) begin
        d_rdata_reg <= {hold_reg, bus.mem_rdata};
      end
    end
  end

  // outputs decoded from the current state and latched request
  always_comb begin
    bus.if_gnt      = 1'b0;
    bus.d_gnt       = 1'b0;
    bus.if_valid    = 1'b0;
    bus.d_valid     = 1'b0;
    bus.mem_r       = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr_r  = '0;
    bus.mem_addr_wr = '0;
    bus.mem_wdata   = '0;
    bus.if_rdata    = if_rdata_reg;
    bus.d_rdata     = d_rdata_reg;
    bus.busy        = (state_reg != IDLE);
    case (state_reg)
      ACC0: begin
        bus.if_gnt      = ~owner_d_reg;
        bus.d_gnt       = owner_d_reg;
        bus.mem_r       = ~we_reg;
        bus.mem_wr      = we_reg;
        bus.mem_addr_r  = addr_reg;
        bus.mem_addr_wr = addr_reg;
        if (we_reg) bus.mem_wdata = wdata_reg[2*DATA_W-1:DATA_W];
      end
      ACC1: begin
        bus.mem_r       = ~we_reg;
        bus.mem_wr      = we_reg;
        bus.mem_addr_r  = addr_inc;
        bus.mem_addr_wr = addr_inc;
        if (we_reg) bus.mem_wdata = wdata_reg[DATA_W-1:0];
      end
      RESP: begin
        bus.if_valid = ~owner_d_reg;
        bus.d_valid  = owner_d_reg;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// starvation and reset-abort sequences, then random single-port traffic
// checked against a word-array reference of the memory.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int LIMIT  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   init_mem = 1'b1;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int i);
    if (i == 16'h10) return 16'h1234;
    if (i == 16'h30) return 16'h00FF;
    return 16'((i * 257) ^ 23100);
  endfunction

  // memory seen by the DUT (256 words, low address byte selects the word)
  logic [15:0] mem_model [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= init_word(i);
    end else if (bus.mem_wr) begin
      mem_model[bus.mem_addr_wr[7:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem_model[bus.mem_addr_r[7:0]];

  // reference contents, updated per completed write transaction
  logic [15:0] ref_mem [256];

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] last_if = '0;
  logic [31:0] last_d  = '0;
  bit          d_known = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input bit dbl, input logic [31:0] addr);
    logic [31:0] a1;
    a1 = addr + 32'd1;
    if (dbl) return {ref_mem[addr[7:0]], ref_mem[a1[7:0]]};
    return {16'h0, ref_mem[addr[7:0]]};
  endfunction

  task automatic ref_write(input bit dbl, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] a1;
    a1 = addr + 32'd1;
    ref_mem[addr[7:0]] = wdata[31:16];
    if (dbl) ref_mem[a1[7:0]] = wdata[15:0];
  endtask

  // One transaction on one port starting from IDLE; checks grant/valid
  // latency, every memory cycle, read data and the other port's quiet state.
  task automatic txn(input string tag, input bit is_d, input bit we, input bit dbl,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic [31:0] exp_a1);
    int          gnt_c;
    int          val_c;
    int          nops;
    bit          other;
    bit          eff_we;
    bit          eff_dbl;
    logic [31:0] got;
    logic [31:0] exp_a;
    gnt_c = -1; val_c = -1; nops = 0; other = 1'b0; got = '0;
    eff_we  = is_d && we;
    eff_dbl = is_d && dbl;
    @(negedge clk);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_dbl = dbl; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int c = 1; c <= 8 && val_c < 0; c++) begin
      @(negedge clk);
      if ((is_d ? bus.d_gnt : bus.if_gnt) && gnt_c < 0) begin
        gnt_c = c;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
      if (is_d ? (bus.if_gnt || bus.if_valid) : (bus.d_gnt || bus.d_valid)) other = 1'b1;
      if (bus.mem_r || bus.mem_wr) begin
        exp_a = (nops == 0) ? addr : exp_a1;
        chk($sformatf("%s/op%0d_addr_r", tag, nops), 64'(bus.mem_addr_r), 64'(exp_a));
        chk($sformatf("%s/op%0d_addr_wr", tag, nops), 64'(bus.mem_addr_wr), 64'(exp_a));
        chk($sformatf("%s/op%0d_r_wr", tag, nops), 64'({bus.mem_r, bus.mem_wr}),
            eff_we ? 64'd1 : 64'd2);
        if (eff_we)
          chk($sformatf("%s/op%0d_wdata", tag, nops), 64'(bus.mem_wdata),
              (nops == 0) ? 64'(wdata[31:16]) : 64'(wdata[15:0]));
        nops++;
      end
      if (is_d ? bus.d_valid : bus.if_valid) begin
        val_c = c;
        got = is_d ? bus.d_rdata : {16'h0, bus.if_rdata};
        chk($sformatf("%s/mem_quiet_in_resp", tag),
            64'({bus.mem_r, bus.mem_wr, bus.mem_addr_r, bus.mem_wdata}), 64'd0);
      end
    end
    chk($sformatf("%s/gnt_latency", tag), 64'(gnt_c), 64'd1);
    chk($sformatf("%s/valid_latency", tag), 64'(val_c), eff_dbl ? 64'd3 : 64'd2);
    chk($sformatf("%s/mem_cycles", tag), 64'(nops), eff_dbl ? 64'd2 : 64'd1);
    chk($sformatf("%s/other_port_quiet", tag), 64'(other), 64'd0);
    if (!eff_we) chk($sformatf("%s/rdata", tag), 64'(got), 64'(exp_rdata));
    if (is_d) chk($sformatf("%s/if_rdata_held", tag), 64'(bus.if_rdata), 64'(last_if));
    else if (d_known) chk($sformatf("%s/d_rdata_held", tag), 64'(bus.d_rdata), 64'(last_d));
    if (!is_d) last_if = exp_rdata[15:0];
    else if (!we) begin last_d = exp_rdata; d_known = 1'b1; end
    else d_known = 1'b0;
    if (eff_we) ref_write(eff_dbl, addr, wdata);
    @(negedge clk);
    chk($sformatf("%s/idle_after", tag), 64'(bus.busy), 64'd0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    bit          dbl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_a1;
  } vec_t;

  vec_t vt [10];

  initial begin
    int          ng;
    bit          seen;
    bit          r_is_d, r_we, r_dbl;
    logic [31:0] r_addr, r_wdata;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_dbl = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h10,       32'h0,        32'h1234,     32'h0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 32'h20,       32'hAAAA5555, 32'h0,        32'h21};
    vt[2] = '{1'b1, 1'b0, 1'b1, 32'h20,       32'h0,        32'hAAAA5555, 32'h21};
    vt[3] = '{1'b0, 1'b0, 1'b0, 32'h21,       32'h0,        32'h5555,     32'h0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h13572468, 32'h0,        32'h0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0,        32'h13572468, 32'h0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'h30,       32'h0,        32'h000000FF, 32'h0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 32'h40,       32'hBEEF0000, 32'h0,        32'h0};
    vt[8] = '{1'b1, 1'b0, 1'b0, 32'h40,       32'h0,        32'h0000BEEF, 32'h0};
    vt[9] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h2468,     32'h0};

    // reset state
    @(negedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    chk("reset/handshake", 64'({bus.if_gnt, bus.if_valid, bus.d_gnt, bus.d_valid, bus.busy}), 64'd0);
    chk("reset/mem_ctrl", 64'({bus.mem_r, bus.mem_wr, bus.mem_wdata}), 64'd0);
    chk("reset/mem_addr", 64'({bus.mem_addr_r, bus.mem_addr_wr}), 64'd0);
    chk("reset/rdata", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/idle_no_req", 64'(bus.busy), 64'd0);

    // directed vectors
    for (int i = 0; i < 10; i++)
      txn($sformatf("vec%0d", i), vt[i].is_d, vt[i].we, vt[i].dbl, vt[i].addr,
          vt[i].wdata, vt[i].exp_rdata, vt[i].exp_a1);

    // both ports held: every (LIMIT+1)th grant goes to fetch
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_dbl = 1'b0; bus.d_addr = 32'h30;
    ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.d_gnt) begin
        chk($sformatf("starve/grant%0d_if_d", ng), 64'({bus.if_gnt, bus.d_gnt}),
            ((ng % (LIMIT + 1)) == LIMIT) ? 64'd2 : 64'd1);
        ng++;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("starve/grants_seen", 64'(ng), 64'd10);
    repeat (3) @(negedge clk);
    chk("starve/if_rdata", 64'(bus.if_rdata), 64'h1234);
    chk("starve/d_rdata", 64'(bus.d_rdata), 64'h000000FF);
    last_if = 16'h1234; last_d = 32'h000000FF; d_known = 1'b1;

    // reset during ACC0 of a write aborts it
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_dbl = 1'b0; bus.d_addr = 32'h50; bus.d_wdata = 32'h77770000;
    @(negedge clk);
    chk("rstmid/in_acc0_gnt_wr", 64'({bus.d_gnt, bus.mem_wr}), 64'd3);
    bus.d_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstmid/mem_wr_dropped", 64'(bus.mem_wr), 64'd0);
    chk("rstmid/busy", 64'(bus.busy), 64'd0);
    chk("rstmid/gnt", 64'(bus.d_gnt), 64'd0);
    chk("rstmid/mem_bus", 64'({bus.mem_addr_wr, bus.mem_wdata}), 64'd0);
    chk("rstmid/rdata_cleared", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.d_valid || bus.busy || bus.mem_wr) seen = 1'b1;
    end
    chk("rstmid/no_valid_after", 64'(seen), 64'd0);
    chk("rstmid/mem_untouched", 64'(mem_model[8'h50]), 64'(init_word(16'h50)));
    last_if = '0; last_d = '0; d_known = 1'b1;

    // random single-port traffic against the reference memory
    for (int t = 0; t < 40; t++) begin
      r_is_d  = ($urandom_range(0, 2) != 0);
      r_we    = r_is_d && ($urandom_range(0, 1) != 0);
      r_dbl   = r_is_d && ($urandom_range(0, 1) != 0);
      r_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 255));
      r_wdata = 32'($urandom);
      txn($sformatf("rnd%0d", t), r_is_d, r_we, r_dbl, r_addr, r_wdata,
          ref_read(r_dbl, r_addr), r_addr + 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port controller placed in front of the shared unified instruction/data memory (ADDR_W-bit address, DATA_W-bit word).
- Arbitrates between the fetch stage (single-word reads) and the memory stage (single- or double-word reads and writes).
- Sequences double-word accesses as two word transfers.
- Drives the memory's read/write enables, addresses and write data; captures read data.

Parameters:
ADDR_W, 32, address width
DATA_W, 16, memory word width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; asynchronous, active-high
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch accepted; 1-cycle pulse
if_valid  out  1  if_rdata valid; 1-cycle pulse
if_rdata  out  DATA_W  fetched word
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = write, 0 = read
d_dbl  in  1  1 = two-word access
d_addr  in  ADDR_W  data word address
d_wdata  in  2*DATA_W  write data; [2*DATA_W-1:DATA_W] goes to addr, low half to addr+1
d_gnt  out  1  data accepted; 1-cycle pulse
d_valid  out  1  completion pulse for reads and writes
d_rdata  out  2*DATA_W  read data; single-word reads zero-extend into the low half
mem_r  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_addr_r  out  ADDR_W  memory read address
mem_addr_wr  out  ADDR_W  memory write address; always equal to mem_addr_r
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid before the posedge that ends a read cycle
busy  out  1  state != IDLE

Behaviour:
- Reset:
  - State IDLE; starvation counter 0.
  - All outputs 0, applied asynchronously.
  - A transfer in flight is aborted: mem_wr drops immediately, no valid is issued, and the latched request is discarded.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - At a posedge with any request, latch the winner's addr, we, dbl and wdata, then go to ACC0.
  - A fetch latch forces we=0 and dbl=0.
- Arbitration:
  - Data wins, except the fetch wins when if_req=1 and the counter equals STARVE_LIMIT.
  - On a data grant with if_req=1, the counter increments, saturating at STARVE_LIMIT.
  - The counter clears on a fetch grant, or on a data grant with if_req=0.
- Grant pulses: if_gnt or d_gnt is high for exactly the ACC0 cycle. A requester may drop req from then on.
- ACC0:
  - Address outputs = latched addr.
  - Read: mem_r=1; mem_rdata is captured at the posedge ending ACC0.
  - Write: mem_wr=1 with mem_wdata = high half of the latched wdata.
  - Next state is ACC1 if dbl, else RESP.
- ACC1:
  - Address = latched addr+1, modulo 2^ADDR_W, so 0xFFFFFFFF wraps to 0.
  - Read: the capture goes to the low half.
  - Write: mem_wdata = low half of the latched wdata.
  - Next state is RESP.
- RESP:
  - Assert the owner's valid and rdata for one cycle; return to IDLE.
  - rdata holds its value until the next completion of the same port.
- Outside ACC0/ACC1: mem_r, mem_wr, addresses and mem_wdata are 0. mem_r and mem_wr are never both 1.
- Latency, measured from the posedge that samples req in IDLE:
  - grant in the next cycle;
  - valid 2 cycles later for a single access;
  - valid 3 cycles later for a double access.
- Throughput: one single access per 3 cycles.
- Requests arriving outside IDLE wait; they are sampled on return to IDLE.
- Simultaneous if_req and d_req follow the arbitration rule above. The losing request keeps waiting and is never lost.

Test Plan:
- Fetch read: memory holds 0x1234 at address 0x10; if_req with if_addr=0x10 -> mem_r=1 with mem_addr_r=0x10 in ACC0; if_valid 2 cycles after sampling with if_rdata=0x1234.
- Double write: d_we=1, d_dbl=1, d_addr=0x20, d_wdata=0xAAAA5555 -> mem_wr at 0x20 with 0xAAAA, then at 0x21 with 0x5555; d_valid 3 cycles after sampling. A following double read of 0x20 returns d_rdata=0xAAAA5555.
- Wrap: double read at d_addr=0xFFFFFFFF -> second access at address 0x00000000.
- Conflict/starvation: if_req and d_req held high continuously -> 4 data grants, then 1 fetch grant, then data resumes; the counter is back to 0 after the fetch grant.
- Reset mid-write: assert rst during ACC0 of a write -> mem_wr is 0 at once; no d_valid; state IDLE; busy=0.
- Single read at 0x30 holding 0x00FF -> d_rdata=0x000000FF; if_valid never pulses.
